// File: rtl/door_lock_pkg.sv
// Shared definitions for the keypad door lock: controller states and the
// default parameter values used by param_door_lock.
package door_lock_pkg;

  typedef enum logic [2:0] {
    LOCKED,
    CHECK,
    UNLOCKED,
    PROG,
    ALARM
  } state_t;

  localparam int          DEF_CODE_LEN       = 4;
  localparam int          DEF_DIGIT_W        = 4;
  localparam logic [15:0] DEF_CODE           = 16'h2234;
  localparam int          DEF_MAX_FAILS      = 3;
  localparam int          DEF_UNLOCK_CYCLES  = 500000;
  localparam int          DEF_LOCKOUT_CYCLES = 1000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/door_timer.sv
// Shared down-counter for the unlock hold and alarm lockout periods.
// done is high whenever the count has reached zero.
module door_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] load_val,
  input  logic         load,
  output logic         done
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/param_door_lock.sv
// Keypad door lock: collects CODE_LEN digits, checks them against a
// programmable stored code, and enforces unlock hold and failure lockout.
module param_door_lock
  import door_lock_pkg::*;
#(
  parameter int                             CODE_LEN       = DEF_CODE_LEN,
  parameter int                             DIGIT_W        = DEF_DIGIT_W,
  parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = DEF_CODE,
  parameter int                             MAX_FAILS      = DEF_MAX_FAILS,
  parameter int                             UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int                             LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIGIT_W-1:0]               key_in,
  input  logic                             enter,
  input  logic                             cancel,
  input  logic                             prog_req,
  input  logic                             lock_req,
  output logic                             locked,
  output logic                             red_light,
  output logic                             green_light,
  output logic                             alarm,
  output logic                             prog_mode,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int CW   = CODE_LEN * DIGIT_W;
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int CNTW = $clog2(CODE_LEN + 1);
  localparam int TW   = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

  state_t          state;
  logic [CW-1:0]   code;
  logic [CW-1:0]   entry;
  logic [CNTW-1:0] digit_cnt;
  logic            enter_q;

  logic            digit;
  logic            last_digit;
  logic            match;
  logic [CW-1:0]   next_entry;
  logic [FW-1:0]   fail_inc;
  logic            to_alarm;
  logic            timer_load;
  logic [TW-1:0]   timer_val;
  logic            timer_done;
  logic            is_open;

  assign digit      = enter & ~enter_q;
  assign last_digit = digit && (digit_cnt == CNTW'(CODE_LEN - 1));
  assign match      = (entry == code);
  assign next_entry = (entry << DIGIT_W) | CW'(key_in);
  assign fail_inc   = (fail_cnt == FW'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;
  assign to_alarm   = (fail_inc == FW'(MAX_FAILS));
  assign is_open    = (state == UNLOCKED) || (state == PROG);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      CHECK: begin
        if (match) begin
          timer_load = 1'b1;
          timer_val  = TW'(UNLOCK_CYCLES);
        end else if (to_alarm) begin
          timer_load = 1'b1;
          timer_val  = TW'(LOCKOUT_CYCLES);
        end
      end
      PROG: begin
        if (!timer_done && !cancel && last_digit) begin
          timer_load = 1'b1;
          timer_val  = TW'(UNLOCK_CYCLES);
        end
      end
      default: ;
    endcase
  end

  door_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_val (timer_val),
    .load     (timer_load),
    .done     (timer_done)
  );

  // Outputs decode the current (pre-edge) state, so they trail it by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOCKED;
      // NOTE: the stored code is an ordinary register, not a RAM, so it can
      // and does take its power-on value from the async reset.
      code        <= DEFAULT_CODE;
      entry       <= '0;
      digit_cnt   <= '0;
      fail_cnt    <= '0;
      enter_q     <= 1'b0;
      locked      <= 1'b1;
      red_light   <= 1'b1;
      green_light <= 1'b0;
      alarm       <= 1'b0;
      prog_mode   <= 1'b0;
    end else begin
      enter_q     <= enter;
      locked      <= ~is_open;
      green_light <= is_open;
      red_light   <= ~is_open && (state != ALARM);
      alarm       <= (state == ALARM);
      prog_mode   <= (state == PROG);

      case (state)
        LOCKED: begin
          if (cancel) begin
            entry     <= '0;
            digit_cnt <= '0;
          end else if (digit) begin
            entry <= next_entry;
            if (last_digit) begin
              digit_cnt <= '0;
              state     <= CHECK;
            end else begin
              digit_cnt <= digit_cnt + 1'b1;
            end
          end
        end

        CHECK: begin
          entry <= '0;
          if (match) begin
            fail_cnt <= '0;
            state    <= UNLOCKED;
          end else begin
            fail_cnt <= fail_inc;
            state    <= to_alarm ? ALARM : LOCKED;
          end
        end

        UNLOCKED: begin
          if (timer_done || lock_req) begin
            state <= LOCKED;
          end else if (prog_req) begin
            state     <= PROG;
            entry     <= '0;
            digit_cnt <= '0;
          end
        end

        PROG: begin
          if (timer_done || cancel) begin
            state     <= timer_done ? LOCKED : UNLOCKED;
            entry     <= '0;
            digit_cnt <= '0;
          end else if (digit) begin
            if (last_digit) begin
              code      <= next_entry;
              entry     <= '0;
              digit_cnt <= '0;
              state     <= UNLOCKED;
            end else begin
              entry     <= next_entry;
              digit_cnt <= digit_cnt + 1'b1;
            end
          end
        end

        ALARM: begin
          if (timer_done) begin
            fail_cnt <= '0;
            state    <= LOCKED;
          end
        end

        default: state <= LOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_param_door_lock.sv
// Randomised bench for param_door_lock with short timeouts; expectations come
// from a small code/fail-count model of the lock's rules.
module tb_param_door_lock;

  localparam int UC = 100;
  localparam int LC = 200;
  localparam int MF = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic       enter, cancel, prog_req, lock_req;
  logic       locked, red_light, green_light, alarm, prog_mode;
  logic [1:0] fail_cnt;

  int vectors = 0;
  int errors  = 0;
  int m_code[4];
  int m_fail;

  param_door_lock #(
    .CODE_LEN(4), .DIGIT_W(4), .DEFAULT_CODE(16'h2234),
    .MAX_FAILS(MF), .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .enter(enter), .cancel(cancel),
    .prog_req(prog_req), .lock_req(lock_req), .locked(locked),
    .red_light(red_light), .green_light(green_light), .alarm(alarm),
    .prog_mode(prog_mode), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One keypress with random hold and release gap; called and returns at a negedge.
  task automatic press(input int d);
    int hold, gap;
    hold   = $urandom_range(1, 3);
    gap    = $urandom_range(1, 3);
    key_in = 4'(d);
    enter  = 1'b1;
    repeat (hold) @(negedge clk);
    enter  = 1'b0;
    key_in = 4'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Final keypress of a code: returns at the negedge right after the accepting edge.
  task automatic press_last(input int d);
    key_in = 4'(d);
    enter  = 1'b1;
    @(negedge clk);
    enter  = 1'b0;
    key_in = 4'($urandom);
  endtask

  task automatic pulse_lock();
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    idle(2);
    vectors++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock: locked=%b want 1", locked);
    end
  endtask

  task automatic attempt(input int d0, input int d1, input int d2, input int d3,
                         input string tag);
    bit ok;
    press(d0); press(d1); press(d2); press_last(d3);
    idle(2);
    ok = (d0 == m_code[0]) && (d1 == m_code[1]) && (d2 == m_code[2]) && (d3 == m_code[3]);
    if (ok) m_fail = 0;
    else    m_fail = (m_fail < MF) ? m_fail + 1 : MF;
    vectors++;
    if (locked !== !ok || fail_cnt !== 2'(m_fail) || alarm !== (m_fail == MF)) begin
      errors++;
      $display("FAIL %s: locked=%b fail_cnt=%0d alarm=%b want locked=%b fail_cnt=%0d alarm=%b",
               tag, locked, fail_cnt, alarm, !ok, m_fail, (m_fail == MF));
    end
  endtask

  task automatic wrong_code(output int w0, output int w1, output int w2, output int w3);
    do begin
      w0 = $urandom_range(0, 15); w1 = $urandom_range(0, 15);
      w2 = $urandom_range(0, 15); w3 = $urandom_range(0, 15);
    end while (w0 == m_code[0] && w1 == m_code[1] && w2 == m_code[2] && w3 == m_code[3]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    m_code = '{2, 2, 3, 4};
    m_fail = 0;
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({locked, red_light, green_light, alarm, prog_mode, fail_cnt} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_outputs: lk/red/grn/alm/prg/fc=%b%b%b%b%b/%0d want 11000/0",
               locked, red_light, green_light, alarm, prog_mode, fail_cnt);
    end
  endtask

  task automatic test_unlock_timing();
    bit relocked;
    press(2); press(2); press(3); press_last(4);
    vectors++;
    if (locked !== 1'b1) begin errors++; $display("FAIL latency_edge1: locked=%b want 1", locked); end
    @(negedge clk);
    vectors++;
    if (locked !== 1'b1) begin errors++; $display("FAIL latency_edge2: locked=%b want 1", locked); end
    @(negedge clk);
    vectors++;
    if (locked !== 1'b0 || green_light !== 1'b1) begin
      errors++;
      $display("FAIL latency_open: locked=%b green=%b want 0 1", locked, green_light);
    end
    for (int i = 1; i < UC; i++) begin
      @(negedge clk);
      vectors++;
      if (locked !== 1'b0) begin errors++; $display("FAIL unlock_hold[%0d]: locked=%b want 0", i, locked); end
    end
    relocked = 1'b0;
    for (int i = 0; i < 6 && !relocked; i++) begin
      @(negedge clk);
      relocked = (locked === 1'b1);
    end
    vectors++;
    if (!relocked || red_light !== 1'b1) begin
      errors++;
      $display("FAIL unlock_expiry: locked=%b red=%b want 1 1", locked, red_light);
    end
  endtask

  task automatic test_lockout();
    int w0, w1, w2, w3;
    bit cleared;
    for (int k = 0; k < MF; k++) begin
      wrong_code(w0, w1, w2, w3);
      attempt(w0, w1, w2, w3, "lockout_attempt");
    end
    for (int i = 1; i < LC; i++) begin
      if (i < LC - 10) begin
        enter    = 1'($urandom);
        key_in   = 4'($urandom);
        cancel   = 1'($urandom);
        prog_req = 1'($urandom);
        lock_req = 1'($urandom);
      end else begin
        {enter, cancel, prog_req, lock_req} = 4'b0;
      end
      @(negedge clk);
      vectors++;
      if (alarm !== 1'b1 || locked !== 1'b1) begin
        errors++;
        $display("FAIL alarm_hold[%0d]: alarm=%b locked=%b want 1 1", i, alarm, locked);
      end
    end
    cleared = 1'b0;
    for (int i = 0; i < 6 && !cleared; i++) begin
      @(negedge clk);
      cleared = (alarm === 1'b0);
    end
    m_fail = 0;
    vectors++;
    if (!cleared || fail_cnt !== 2'd0 || locked !== 1'b1 || red_light !== 1'b1) begin
      errors++;
      $display("FAIL alarm_expiry: alarm=%b fail_cnt=%0d locked=%b red=%b want 0 0 1 1",
               alarm, fail_cnt, locked, red_light);
    end
    attempt(m_code[0], m_code[1], m_code[2], m_code[3], "after_alarm_unlock");
    pulse_lock();
  endtask

  task automatic test_enter_hold_cancel();
    key_in = 4'(m_code[0]);
    enter  = 1'b1;
    repeat (5) @(negedge clk);
    enter  = 1'b0;
    idle(2);
    press(m_code[1]); press(m_code[2]); press_last(m_code[3]);
    idle(2);
    vectors++;
    if (locked !== 1'b0) begin errors++; $display("FAIL held_enter: locked=%b want 0", locked); end
    pulse_lock();

    press($urandom_range(0, 15)); press($urandom_range(0, 15));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    attempt(m_code[0], m_code[1], m_code[2], m_code[3], "cancel_partial");
    pulse_lock();

    press(m_code[0]); press(m_code[1]); press(m_code[2]);
    key_in = 4'(m_code[3]);
    enter  = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    {enter, cancel} = 2'b00;
    idle(3);
    vectors++;
    if (locked !== 1'b1 || fail_cnt !== 2'(m_fail)) begin
      errors++;
      $display("FAIL cancel_with_enter: locked=%b fail_cnt=%0d want 1 %0d", locked, fail_cnt, m_fail);
    end
    attempt(m_code[0], m_code[1], m_code[2], m_code[3], "after_cancel_enter");
    pulse_lock();
  endtask

  task automatic test_program();
    int o[4];
    int n0, n1, n2, n3;
    o = m_code;
    attempt(m_code[0], m_code[1], m_code[2], m_code[3], "prog_unlock");
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
    idle(2);
    vectors++;
    if (prog_mode !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL prog_enter: prog_mode=%b locked=%b want 1 0", prog_mode, locked);
    end
    wrong_code(n0, n1, n2, n3);
    press(n0); press(n1); press(n2); press_last(n3);
    idle(2);
    m_code = '{n0, n1, n2, n3};
    vectors++;
    if (prog_mode !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL prog_done: prog_mode=%b locked=%b want 0 0", prog_mode, locked);
    end
    pulse_lock();
    attempt(o[0], o[1], o[2], o[3], "old_code_rejected");
    attempt(n0, n1, n2, n3, "new_code_accepted");
    pulse_lock();
  endtask

  task automatic test_reset_mid_prog_and_expiry();
    bit relocked;
    attempt(m_code[0], m_code[1], m_code[2], m_code[3], "pre_reset_unlock");
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
    press($urandom_range(0, 15)); press($urandom_range(0, 15));
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (locked !== 1'b1 || prog_mode !== 1'b0 || green_light !== 1'b0 || fail_cnt !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: locked=%b prog=%b green=%b fail_cnt=%0d want 1 0 0 0",
               locked, prog_mode, green_light, fail_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_code = '{2, 2, 3, 4};
    m_fail = 0;
    idle(1);
    attempt(2, 2, 3, 4, "default_after_reset");
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
    press($urandom_range(0, 15));
    relocked = 1'b0;
    for (int i = 0; i < UC + 20 && !relocked; i++) begin
      @(negedge clk);
      relocked = (locked === 1'b1);
    end
    vectors++;
    if (!relocked || prog_mode !== 1'b0) begin
      errors++;
      $display("FAIL prog_expiry: locked=%b prog_mode=%b want 1 0", locked, prog_mode);
    end
    attempt(2, 2, 3, 4, "code_kept_after_prog_expiry");
    pulse_lock();
  endtask

  task automatic test_random_attempts();
    int w0, w1, w2, w3;
    for (int it = 0; it < 8; it++) begin
      if (m_fail == MF - 1 || $urandom_range(0, 1) == 1) begin
        attempt(m_code[0], m_code[1], m_code[2], m_code[3], "random_good");
        pulse_lock();
      end else begin
        wrong_code(w0, w1, w2, w3);
        attempt(w0, w1, w2, w3, "random_bad");
      end
    end
  endtask

  initial begin
    {enter, cancel, prog_req, lock_req} = 4'b0;
    key_in = 4'd0;
    @(negedge clk);
    test_reset();
    test_unlock_timing();
    test_lockout();
    test_enter_hold_cancel();
    test_program();
    test_reset_mid_prog_and_expiry();
    test_random_attempts();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/param_door_lock.md
PARAM_DOOR_LOCK -- requirements
Module: param_door_lock

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, number of digits per code.
REQ-002 SHALL have parameter DIGIT_W, default 4, bits per digit.
REQ-003 SHALL have parameter DEFAULT_CODE, default 16'h2234 (CODE_LEN*DIGIT_W bits), power-on code; first digit in the MS nibble.
REQ-004 SHALL have parameter MAX_FAILS, default 3, consecutive wrong codes before lockout.
REQ-005 SHALL have parameter UNLOCK_CYCLES, default 500000, unlocked hold time in clocks.
REQ-006 SHALL have parameter LOCKOUT_CYCLES, default 1000000, alarm lockout time in clocks.
REQ-007 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: key_in in DIGIT_W, digit value; enter in 1, digit strobe; cancel in 1, discard partial entry or abort programming.
REQ-009 SHALL have ports: prog_req in 1, request code change; lock_req in 1, relock immediately.
REQ-010 SHALL have ports: locked out 1; red_light out 1; green_light out 1; alarm out 1; prog_mode out 1; fail_cnt out $clog2(MAX_FAILS+1).

Function
REQ-011 SHALL accept a digit only on the clock where enter=1 and the registered previous enter=0; an enter held N cycles counts once; key_in sampled that same clock.
REQ-012 SHALL implement states LOCKED, CHECK, UNLOCKED, PROG, ALARM, all registered.
REQ-013 LOCKED: accepted digits shift into the entry register; on the CODE_LEN-th digit go to CHECK next clock.
REQ-014 CHECK: compare entry to stored code in one cycle; match -> UNLOCKED, fail_cnt=0, timer loaded with UNLOCK_CYCLES; mismatch -> fail_cnt+1, to ALARM if the new count equals MAX_FAILS, else LOCKED; entry cleared either way.
REQ-015 locked SHALL fall exactly 2 clocks after the edge accepting the final correct digit.
REQ-016 UNLOCKED: digits ignored; timer expiry or lock_req -> LOCKED; prog_req -> PROG with entry cleared, timer not reloaded; lock_req wins over simultaneous prog_req.
REQ-017 PROG: CODE_LEN accepted digits overwrite stored code and return to UNLOCKED with timer reloaded; cancel -> UNLOCKED, code unchanged, timer not reloaded; timer expiry -> LOCKED, code unchanged.
REQ-018 ALARM: timer loaded with LOCKOUT_CYCLES on entry; enter, cancel, prog_req, lock_req ignored; expiry -> LOCKED with fail_cnt=0.
REQ-019 cancel in LOCKED SHALL clear the partial entry and digit count, fail_cnt untouched; cancel wins over a simultaneous enter edge.
REQ-020 Timer expiry in the same clock as an enter edge SHALL discard the digit.
REQ-021 fail_cnt SHALL saturate at MAX_FAILS and never wrap.
REQ-022 Outputs decoded from state: locked=1 except in UNLOCKED/PROG; green_light=~locked; red_light=locked & ~alarm; alarm=(ALARM); prog_mode=(PROG).
REQ-023 A single down-counter of width $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1) SHALL serve both timeouts; expiry = counter reaching 0 while in a timed state.

Reset
REQ-024 rst_n low SHALL asynchronously force state LOCKED, stored code DEFAULT_CODE, entry/digit count/fail_cnt/timer/enter history to 0.
REQ-025 Reset outputs: locked=1, red_light=1, green_light=0, alarm=0, prog_mode=0, fail_cnt=0; reset mid-PROG or mid-ALARM discards all progress.

Structure
REQ-026 A shared package door_lock_pkg SHALL hold the state enumeration and default parameter constants.
REQ-027 The timer SHALL be sub-module door_timer (load value, load strobe, done flag).

Verification (UNLOCK_CYCLES=100, LOCKOUT_CYCLES=200, MAX_FAILS=3)
REQ-028 Reset, enter 2,2,3,4 -> locked=0/green=1 two clocks after last digit; locked=1 again after 100 clocks.
REQ-029 Three entries 1,1,1,1 -> fail_cnt 1,2,3; alarm=1 for 200 clocks with digits ignored; then LOCKED, fail_cnt=0.
REQ-030 Unlock, prog_req, enter 5,6,7,8, lock_req; 2,2,3,4 -> fail_cnt=1; 5,6,7,8 -> unlock, fail_cnt=0.
REQ-031 enter held 5 clocks with key 2 -> one digit; cancel after 2 digits then 2,2,3,4 -> unlock; cancel+enter same clock -> no digit.
REQ-032 Reset mid-PROG after 2 digits -> locked=1, code 2,2,3,4 unlocks; timer expiry in PROG -> locked=1, old code retained.
